// File: rtl/serial_chunk_adder_if.sv
// Purpose : operand/result handshake bundle for serial_chunk_adder.
// Latency : none; wires only.
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
//
// Signals (direction as seen by the adder, modport slave):
//   in_valid  in   operands a, b, cin valid
//   in_ready  out  adder can accept operands
//   a, b      in   WIDTH-bit operands
//   cin       in   carry-in
//   out_valid out  sum/cout valid
//   out_ready in   consumer accepts result
//   sum       out  WIDTH-bit result
//   cout      out  carry out of bit WIDTH-1
//   ovf       out  signed overflow, only when SCA_OVERFLOW_EN is defined
interface serial_chunk_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SCA_OVERFLOW_EN
    logic             ovf;
`endif

    // Producer/consumer side.
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
`ifdef SCA_OVERFLOW_EN
        , ovf
`endif
    );

    // Adder side.
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
`ifdef SCA_OVERFLOW_EN
        , ovf
`endif
    );
endinterface

// File: rtl/serial_chunk_adder.sv
// Purpose : computes a+b+cin over WIDTH bits with one CHUNK-bit adder slice, CHUNK bits per clock.
// Latency : WIDTH/CHUNK cycles from acceptance edge to out_valid; one operation per WIDTH/CHUNK+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, with in_ready low meanwhile.
//
// Ports:
//   clk   rising-edge clock
//   rstn  asynchronous active-low reset; aborts any operation in flight
//   io    serial_chunk_adder_if.slave (operand handshake, result handshake, sum/cout[/ovf])
// Optional feature: define SCA_OVERFLOW_EN to add the registered signed-overflow output ovf.
// All outputs come straight from flops; there is no combinational input-to-output path.
module serial_chunk_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    serial_chunk_adder_if.slave   io
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    // Reject parameterisations the slice addressing cannot represent.
    generate
        if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("serial_chunk_adder: WIDTH must be a positive multiple of CHUNK, 1 <= CHUNK <= WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   sum_r;
    logic [WIDTH-1:0]   sum_next;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               in_rdy;
    logic               out_vld;
    logic               cout_r;
`ifdef SCA_OVERFLOW_EN
    logic               ovf_r;
`endif

    logic [CHUNK-1:0]   slice_a;
    logic [CHUNK-1:0]   slice_b;
    logic [CHUNK-1:0]   slice_sum;
    logic               slice_cout;

    // Select the operand chunk addressed by the counter.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (cnt == CNT_W'(i)) begin
                slice_a = op_a[i*CHUNK +: CHUNK];
                slice_b = op_b[i*CHUNK +: CHUNK];
            end
        end
    end

    // The single shared adder slice.
    always_comb begin
        {slice_cout, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {{CHUNK{1'b0}}, carry};
    end

    // Drop the slice result into its chunk of the sum register.
    always_comb begin
        sum_next = sum_r;
        for (int i = 0; i < NCHUNK; i++) begin
            if (cnt == CNT_W'(i)) begin
                sum_next[i*CHUNK +: CHUNK] = slice_sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_IDLE;
            op_a    <= '0;
            op_b    <= '0;
            sum_r   <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            in_rdy  <= 1'b1;
            out_vld <= 1'b0;
            cout_r  <= 1'b0;
`ifdef SCA_OVERFLOW_EN
            ovf_r   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (io.in_valid) begin
                        // Capture operands so later input changes cannot disturb the running add.
                        op_a    <= io.a;
                        op_b    <= io.b;
                        carry   <= io.cin;
                        cnt     <= '0;
                        sum_r   <= '0;
                        cout_r  <= 1'b0;
`ifdef SCA_OVERFLOW_EN
                        ovf_r   <= 1'b0;
`endif
                        in_rdy  <= 1'b0;
                        state   <= S_CALC;
                    end
                end

                S_CALC: begin
                    sum_r <= sum_next;
                    carry <= slice_cout;
                    if (cnt == LAST_CNT) begin
                        cout_r  <= slice_cout;
`ifdef SCA_OVERFLOW_EN
                        // The final slice holds the sum MSB, so overflow is known this cycle.
                        ovf_r   <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                                   (slice_sum[CHUNK-1] != op_a[WIDTH-1]);
`endif
                        out_vld <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_DONE: begin
                    if (io.out_ready) begin
                        out_vld <= 1'b0;
                        in_rdy  <= 1'b1;
                        state   <= S_IDLE;
                    end
                end

                default: begin
                    out_vld <= 1'b0;
                    in_rdy  <= 1'b1;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    assign io.in_ready  = in_rdy;
    assign io.out_valid = out_vld;
    assign io.sum       = sum_r;
    assign io.cout      = cout_r;
`ifdef SCA_OVERFLOW_EN
    assign io.ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Purpose : directed and randomised checks of serial_chunk_adder (CHUNK 8 main unit, CHUNK 1/4/32 sweep units).
// Latency : expects out_valid exactly WIDTH/CHUNK cycles after the acceptance edge.
// Backpressure: exercises out_ready held low with a competing in_valid pulse.
module tb_serial_chunk_adder;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_chunk_adder_if #(.WIDTH(32)) m_if ();
    serial_chunk_adder_if #(.WIDTH(32)) s1_if ();
    serial_chunk_adder_if #(.WIDTH(32)) s4_if ();
    serial_chunk_adder_if #(.WIDTH(32)) s32_if ();

    serial_chunk_adder #(.WIDTH(32), .CHUNK(8))  dut     (.clk(clk), .rstn(rstn), .io(m_if.slave));
    serial_chunk_adder #(.WIDTH(32), .CHUNK(1))  dut_c1  (.clk(clk), .rstn(rstn), .io(s1_if.slave));
    serial_chunk_adder #(.WIDTH(32), .CHUNK(4))  dut_c4  (.clk(clk), .rstn(rstn), .io(s4_if.slave));
    serial_chunk_adder #(.WIDTH(32), .CHUNK(32)) dut_c32 (.clk(clk), .rstn(rstn), .io(s32_if.slave));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands to the main unit, then scramble the inputs and wait for out_valid.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic ci, output int lat);
        m_if.a        = a;
        m_if.b        = b;
        m_if.cin      = ci;
        m_if.in_valid = 1'b1;
        tick();
        m_if.in_valid = 1'b0;
        m_if.a        = ~a;
        m_if.b        = ~b;
        m_if.cin      = ~ci;
        chk("calc_in_ready", 64'(m_if.in_ready), 64'd0);
        chk("calc_out_valid", 64'(m_if.out_valid), 64'd0);
        lat = -1;
        for (int c = 1; c <= 64 && lat < 0; c++) begin
            tick();
            if (m_if.out_valid === 1'b1) lat = c;
        end
    endtask

    task automatic release_op();
        m_if.out_ready = 1'b1;
        tick();
        m_if.out_ready = 1'b0;
        chk("idle_out_valid", 64'(m_if.out_valid), 64'd0);
        chk("idle_in_ready", 64'(m_if.in_ready), 64'd1);
    endtask

    task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b, input logic ci,
                           input logic [31:0] exp_sum, input logic exp_cout);
        int lat;
        start_op(a, b, ci, lat);
        chk({tag, "_latency"}, 64'(lat), 64'd4);
        chk({tag, "_sum"}, 64'(m_if.sum), 64'(exp_sum));
        chk({tag, "_cout"}, 64'(m_if.cout), 64'(exp_cout));
        release_op();
    endtask

`ifdef SCA_OVERFLOW_EN
    task automatic run_ovf(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_sum, input logic exp_cout, input logic exp_ovf);
        int lat;
        start_op(a, b, 1'b0, lat);
        chk({tag, "_latency"}, 64'(lat), 64'd4);
        chk({tag, "_sum"}, 64'(m_if.sum), 64'(exp_sum));
        chk({tag, "_cout"}, 64'(m_if.cout), 64'(exp_cout));
        chk({tag, "_ovf"}, 64'(m_if.ovf), 64'(exp_ovf));
        release_op();
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time bound");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat;
        int          l1, l4, l32;
        logic [31:0] ra, rb;
        logic        rc;
        logic [32:0] exp33;

        m_if.in_valid = 1'b0;  m_if.out_ready = 1'b0;  m_if.a = '0;  m_if.b = '0;  m_if.cin = 1'b0;
        s1_if.in_valid = 1'b0; s1_if.out_ready = 1'b0; s1_if.a = '0; s1_if.b = '0; s1_if.cin = 1'b0;
        s4_if.in_valid = 1'b0; s4_if.out_ready = 1'b0; s4_if.a = '0; s4_if.b = '0; s4_if.cin = 1'b0;
        s32_if.in_valid = 1'b0; s32_if.out_ready = 1'b0; s32_if.a = '0; s32_if.b = '0; s32_if.cin = 1'b0;

        // Reset state.
        repeat (3) tick();
        rstn = 1'b1;
        tick();
        chk("rst_in_ready", 64'(m_if.in_ready), 64'd1);
        chk("rst_out_valid", 64'(m_if.out_valid), 64'd0);
        chk("rst_sum", 64'(m_if.sum), 64'd0);
        chk("rst_cout", 64'(m_if.cout), 64'd0);
`ifdef SCA_OVERFLOW_EN
        chk("rst_ovf", 64'(m_if.ovf), 64'd0);
`endif

        // Directed vectors.
        run_vec("carry_chunk0", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0);
        run_vec("ripple_all",   32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1);
        run_vec("msb_carry",    32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1);
        run_vec("plain",        32'h0102_0304, 32'h1020_3040, 1'b1, 32'h1122_3345, 1'b0);

        // Backpressure with a competing operand pulse.
        start_op(32'h1234_0000, 32'h0000_5678, 1'b0, lat);
        chk("bp_latency", 64'(lat), 64'd4);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                m_if.a        = 32'h0000_0001;
                m_if.b        = 32'h0000_0001;
                m_if.cin      = 1'b0;
                m_if.in_valid = 1'b1;
            end
            tick();
            m_if.in_valid = 1'b0;
            chk("bp_out_valid", 64'(m_if.out_valid), 64'd1);
            chk("bp_in_ready", 64'(m_if.in_ready), 64'd0);
            chk("bp_sum", 64'(m_if.sum), 64'h1234_5678);
            chk("bp_cout", 64'(m_if.cout), 64'd0);
        end
        release_op();
        run_vec("after_bp", 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0);

        // Reset two cycles into the calculation.
        m_if.a        = 32'hAAAA_AAAA;
        m_if.b        = 32'h5555_5555;
        m_if.cin      = 1'b1;
        m_if.in_valid = 1'b1;
        tick();
        m_if.in_valid = 1'b0;
        tick();
        tick();
        rstn = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(m_if.out_valid), 64'd0);
        chk("midrst_sum", 64'(m_if.sum), 64'd0);
        chk("midrst_cout", 64'(m_if.cout), 64'd0);
        tick();
        tick();
        rstn = 1'b1;
        tick();
        chk("postrst_in_ready", 64'(m_if.in_ready), 64'd1);
        chk("postrst_out_valid", 64'(m_if.out_valid), 64'd0);
        run_vec("postrst", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0);

`ifdef SCA_OVERFLOW_EN
        run_ovf("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
        run_ovf("ovf_neg", 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1);
        run_ovf("ovf_mix", 32'h0000_0005, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 1'b0);
`endif

        // Random sweep over CHUNK = 1, 4, 32, all three units run side by side.
        for (int n = 0; n < 1000; n++) begin
            ra    = $urandom;
            rb    = $urandom;
            rc    = 1'($urandom_range(0, 1));
            exp33 = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
            s1_if.a = ra;  s1_if.b = rb;  s1_if.cin = rc;  s1_if.in_valid = 1'b1;
            s4_if.a = ra;  s4_if.b = rb;  s4_if.cin = rc;  s4_if.in_valid = 1'b1;
            s32_if.a = ra; s32_if.b = rb; s32_if.cin = rc; s32_if.in_valid = 1'b1;
            tick();
            s1_if.in_valid = 1'b0; s4_if.in_valid = 1'b0; s32_if.in_valid = 1'b0;
            s1_if.a = ~ra; s4_if.b = ~rb; s32_if.cin = ~rc;
            l1 = -1; l4 = -1; l32 = -1;
            for (int c = 1; c <= 40 && (l1 < 0 || l4 < 0 || l32 < 0); c++) begin
                tick();
                if (l1 < 0 && s1_if.out_valid === 1'b1) l1 = c;
                if (l4 < 0 && s4_if.out_valid === 1'b1) l4 = c;
                if (l32 < 0 && s32_if.out_valid === 1'b1) l32 = c;
            end
            chk("c1_latency", 64'(l1), 64'd32);
            chk("c4_latency", 64'(l4), 64'd8);
            chk("c32_latency", 64'(l32), 64'd1);
            chk("c1_result", 64'({s1_if.cout, s1_if.sum}), 64'(exp33));
            chk("c4_result", 64'({s4_if.cout, s4_if.sum}), 64'(exp33));
            chk("c32_result", 64'({s32_if.cout, s32_if.sum}), 64'(exp33));
            s1_if.out_ready = 1'b1; s4_if.out_ready = 1'b1; s32_if.out_ready = 1'b1;
            tick();
            s1_if.out_ready = 1'b0; s4_if.out_ready = 1'b0; s32_if.out_ready = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
